// File: rtl/csi2tx_ecc_24b_dec.sv
// Two-stage ECC checker/corrector for 24-bit CSI-2 packet headers.
// Stage 1 captures the header and syndrome. Stage 2 corrects the header and drives the registered status.
module csi2tx_ecc_24b_dec #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             txbyteclkhs,
  input  logic             txbyteclkhs_rst_n,
  input  logic             tinit_start,
  input  logic             hdr_valid,
  input  logic [23:0]      hdr_in,
  input  logic [5:0]       ecc_in,
  input  logic             err_cnt_clr,
  output logic [23:0]      hdr_out,
  output logic             hdr_out_valid,
  output logic             ecc_corrected,
  output logic             ecc_uncorrectable,
  output logic [4:0]       err_bit_pos,
  output logic [CNT_W-1:0] single_err_cnt,
  output logic [CNT_W-1:0] multi_err_cnt
);

  localparam int unsigned HDR_W = 24;
  localparam int unsigned ECC_W = 6;
  localparam int unsigned POS_W = 5;
  localparam logic [POS_W-1:0] POS_ECC = 5'd31;

  // Parity-bit membership of each header bit; also its single-bit syndrome.
  function automatic logic [ECC_W-1:0] col(input int unsigned n);
    case (n)
      0:  col = 6'h07;  1:  col = 6'h0B;  2:  col = 6'h0D;  3:  col = 6'h0E;
      4:  col = 6'h13;  5:  col = 6'h15;  6:  col = 6'h16;  7:  col = 6'h19;
      8:  col = 6'h1A;  9:  col = 6'h1C;  10: col = 6'h23;  11: col = 6'h25;
      12: col = 6'h26;  13: col = 6'h29;  14: col = 6'h2A;  15: col = 6'h2C;
      16: col = 6'h31;  17: col = 6'h32;  18: col = 6'h34;  19: col = 6'h38;
      20: col = 6'h1F;  21: col = 6'h2F;  22: col = 6'h37;  23: col = 6'h3B;
      default: col = '0;
    endcase
  endfunction

  function automatic logic [ECC_W-1:0] parity(input logic [HDR_W-1:0] h);
    logic [ECC_W-1:0] p;
    p = '0;
    for (int unsigned n = 0; n < HDR_W; n++) begin
      if (h[n]) p = p ^ col(n);
    end
    return p;
  endfunction

  logic [ECC_W-1:0] syn_c;
  logic             s1_valid;
  logic [HDR_W-1:0] s1_hdr;
  logic [ECC_W-1:0] s1_syn;

  assign syn_c = parity(hdr_in) ^ ecc_in;

  // Stage 1: data registers hold when no header is offered.
  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      s1_valid <= 1'b0;
      s1_hdr   <= '0;
      s1_syn   <= '0;
    end else if (!tinit_start) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= hdr_valid;
      if (hdr_valid) begin
        s1_hdr <= hdr_in;
        s1_syn <= syn_c;
      end
    end
  end

  logic [HDR_W-1:0] flip_c;
  logic [POS_W-1:0] pos_c;
  logic             corr_c;
  logic             unc_c;
  logic             hit_c;

  // Syndrome lookup: a data column, a one-hot ECC bit, or uncorrectable.
  always_comb begin
    flip_c = '0;
    pos_c  = '0;
    corr_c = 1'b0;
    unc_c  = 1'b0;
    hit_c  = 1'b0;
    if (s1_syn != '0) begin
      if ($onehot(s1_syn)) begin
        corr_c = 1'b1;
        pos_c  = POS_ECC;
      end else begin
        for (int unsigned n = 0; n < HDR_W; n++) begin
          if (s1_syn == col(n)) begin
            flip_c[n] = 1'b1;
            pos_c     = POS_W'(n);
            hit_c     = 1'b1;
          end
        end
        corr_c = hit_c;
        unc_c  = !hit_c;
      end
    end
  end

  // Stage 2: outputs are zero whenever no header is being presented.
  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      hdr_out           <= '0;
      hdr_out_valid     <= 1'b0;
      ecc_corrected     <= 1'b0;
      ecc_uncorrectable <= 1'b0;
      err_bit_pos       <= '0;
    end else if (!tinit_start || !s1_valid) begin
      hdr_out           <= '0;
      hdr_out_valid     <= 1'b0;
      ecc_corrected     <= 1'b0;
      ecc_uncorrectable <= 1'b0;
      err_bit_pos       <= '0;
    end else begin
      hdr_out           <= s1_hdr ^ flip_c;
      hdr_out_valid     <= 1'b1;
      ecc_corrected     <= corr_c;
      ecc_uncorrectable <= unc_c;
      err_bit_pos       <= pos_c;
    end
  end

  logic inc_single_c;
  logic inc_multi_c;

  // A header still on the outputs when tinit_start drops is discarded, not counted.
  assign inc_single_c = hdr_out_valid && ecc_corrected && tinit_start;
  assign inc_multi_c  = hdr_out_valid && ecc_uncorrectable && tinit_start;

  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      single_err_cnt <= '0;
      multi_err_cnt  <= '0;
    end else if (err_cnt_clr) begin
      single_err_cnt <= '0;
      multi_err_cnt  <= '0;
    end else begin
      if (inc_single_c && (single_err_cnt != '1)) single_err_cnt <= single_err_cnt + CNT_W'(1);
      if (inc_multi_c && (multi_err_cnt != '1))   multi_err_cnt  <= multi_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_csi2tx_ecc_24b_dec.sv
// Randomized bench for csi2tx_ecc_24b_dec. The reference decodes by brute-force search for the nearest codeword.
// Two instances run in parallel, one at CNT_W=8 and one at CNT_W=2 to exercise counter saturation.
module tb_csi2tx_ecc_24b_dec;

  localparam logic [5:0] COLS [0:23] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C,
    6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38,
    6'h1F, 6'h2F, 6'h37, 6'h3B};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tinit;
  logic        hv;
  logic [23:0] hin;
  logic [5:0]  ein;
  logic        clr;

  logic [23:0] ho8, ho2;
  logic        ov8, ov2, c8, c2, u8, u2;
  logic [4:0]  p8, p2;
  logic [7:0]  sc8, mc8;
  logic [1:0]  sc2, mc2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  csi2tx_ecc_24b_dec #(.CNT_W(8)) dut (
    .txbyteclkhs(clk), .txbyteclkhs_rst_n(rst_n), .tinit_start(tinit),
    .hdr_valid(hv), .hdr_in(hin), .ecc_in(ein), .err_cnt_clr(clr),
    .hdr_out(ho8), .hdr_out_valid(ov8), .ecc_corrected(c8),
    .ecc_uncorrectable(u8), .err_bit_pos(p8),
    .single_err_cnt(sc8), .multi_err_cnt(mc8));

  csi2tx_ecc_24b_dec #(.CNT_W(2)) dut2 (
    .txbyteclkhs(clk), .txbyteclkhs_rst_n(rst_n), .tinit_start(tinit),
    .hdr_valid(hv), .hdr_in(hin), .ecc_in(ein), .err_cnt_clr(clr),
    .hdr_out(ho2), .hdr_out_valid(ov2), .ecc_corrected(c2),
    .ecc_uncorrectable(u2), .err_bit_pos(p2),
    .single_err_cnt(sc2), .multi_err_cnt(mc2));

  function automatic logic [5:0] mparity(input logic [23:0] h);
    logic [5:0] p = '0;
    for (int n = 0; n < 24; n++) if (h[n]) p ^= COLS[n];
    return p;
  endfunction

  // Nearest-codeword search: clean, one data bit off, one ECC bit off, else uncorrectable.
  task automatic mdecode(input logic [23:0] h, input logic [5:0] e,
                         output logic [23:0] ho, output logic c, output logic u,
                         output logic [4:0] p);
    ho = h; c = 1'b0; u = 1'b0; p = 5'd0;
    if (mparity(h) != e) begin
      u = 1'b1;
      for (int n = 0; n < 24; n++) begin
        if (mparity(h ^ (24'd1 << n)) == e) begin
          ho = h ^ (24'd1 << n); c = 1'b1; u = 1'b0; p = 5'(n);
        end
      end
      for (int k = 0; k < 6; k++) begin
        if (mparity(h) == (e ^ (6'd1 << k))) begin
          c = 1'b1; u = 1'b0; p = 5'd31;
        end
      end
    end
  endtask

  logic        m_s1v, m_ov, m_c, m_u;
  logic [23:0] m_s1h, m_ho;
  logic [5:0]  m_s1e;
  logic [4:0]  m_p;
  int          m_sc8, m_mc8, m_sc2, m_mc2;
  logic [23:0] t_ho;
  logic        t_c, t_u;
  logic [4:0]  t_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1v <= 0; m_s1h <= '0; m_s1e <= '0;
      m_ov <= 0; m_ho <= '0; m_c <= 0; m_u <= 0; m_p <= '0;
      m_sc8 <= 0; m_mc8 <= 0; m_sc2 <= 0; m_mc2 <= 0;
    end else begin
      if (clr) begin
        m_sc8 <= 0; m_mc8 <= 0; m_sc2 <= 0; m_mc2 <= 0;
      end else if (tinit && m_ov) begin
        if (m_c) begin m_sc8 <= (m_sc8 < 255) ? m_sc8 + 1 : 255; m_sc2 <= (m_sc2 < 3) ? m_sc2 + 1 : 3; end
        if (m_u) begin m_mc8 <= (m_mc8 < 255) ? m_mc8 + 1 : 255; m_mc2 <= (m_mc2 < 3) ? m_mc2 + 1 : 3; end
      end
      if (!tinit) begin
        m_s1v <= 0; m_ov <= 0; m_c <= 0; m_u <= 0;
      end else begin
        m_s1v <= hv;
        if (hv) begin m_s1h <= hin; m_s1e <= ein; end
        mdecode(m_s1h, m_s1e, t_ho, t_c, t_u, t_p);
        m_ov <= m_s1v;
        m_ho <= t_ho;
        m_c  <= m_s1v & t_c;
        m_u  <= m_s1v & t_u;
        m_p  <= t_p;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 32'(ov8), 32'(m_ov));
      chk("corrected", 32'(c8), 32'(m_c));
      chk("uncorrectable", 32'(u8), 32'(m_u));
      chk("valid2", 32'(ov2), 32'(m_ov));
      chk("corrected2", 32'(c2), 32'(m_c));
      chk("uncorrectable2", 32'(u2), 32'(m_u));
      if (m_ov) begin
        chk("hdr_out", 32'(ho8), 32'(m_ho));
        chk("err_bit_pos", 32'(p8), 32'(m_p));
        chk("hdr_out2", 32'(ho2), 32'(m_ho));
        chk("err_bit_pos2", 32'(p2), 32'(m_p));
      end
      chk("single_cnt8", 32'(sc8), 32'(m_sc8));
      chk("multi_cnt8", 32'(mc8), 32'(m_mc8));
      chk("single_cnt2", 32'(sc2), 32'(m_sc2));
      chk("multi_cnt2", 32'(mc2), 32'(m_mc2));
    end
  end

  task automatic drive(input logic [23:0] h, input logic [5:0] e, input logic v,
                       input logic cl, input logic ti);
    hin = h; ein = e; hv = v; clr = cl; tinit = ti;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(24'd0, 6'd0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [23:0] rh, eh;
  logic [5:0]  re;
  logic [23:0] d_ho;
  logic        d_c, d_u;
  logic [4:0]  d_p;
  int          kind, a, b;

  initial begin
    rst_n = 0; tinit = 1; hv = 0; hin = '0; ein = '0; clr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (10) idle();
    chk("reset_hdr_out", 32'(ho8), 32'h0);
    chk("reset_cnts", {8'(sc8), 8'(mc8), 6'd0, sc2, 6'd0, mc2}, 32'h0);

    // Hand-computed values that pin the reference decoder.
    mdecode(24'h000000, 6'h07, d_ho, d_c, d_u, d_p);
    chk("model_d0", {d_ho, 1'b0, d_c, d_u, d_p}, {24'h000001, 1'b0, 1'b1, 1'b0, 5'd0});
    mdecode(24'h000002, 6'h07, d_ho, d_c, d_u, d_p);
    chk("model_double", {d_ho, 1'b0, d_c, d_u, d_p}, {24'h000002, 1'b0, 1'b0, 1'b1, 5'd0});

    drive(24'h000001, 6'h07, 1, 0, 1); idle();
    chk("clean_hdr", 32'(ho8), 32'h000001);
    chk("clean_flags", {29'd0, ov8, c8, u8}, 32'b100);
    idle();
    chk("clean_cnt", 32'(sc8), 32'd0);

    drive(24'h000000, 6'h07, 1, 0, 1); idle();
    chk("d0_hdr", 32'(ho8), 32'h000001);
    chk("d0_pos", {26'd0, c8, p8}, {26'd0, 1'b1, 5'd0});
    idle();
    chk("d0_cnt", 32'(sc8), 32'd1);

    drive(24'h000001, 6'h06, 1, 0, 1); idle();
    chk("eccbit", {ho8, 2'd0, c8, p8}, {24'h000001, 2'd0, 1'b1, 5'd31});
    idle();

    drive(24'h000002, 6'h07, 1, 0, 1); idle();
    chk("double", {ho8, 2'd0, u8, p8}, {24'h000002, 2'd0, 1'b1, 5'd0});
    idle();
    chk("double_cnt", {24'd0, mc8}, 32'd1);

    // Sweep a single flipped bit across a random header, back-to-back.
    rh = 24'($urandom);
    re = mparity(rh);
    for (int n = 0; n < 24; n++) drive(rh ^ (24'd1 << n), re, 1, 0, 1);
    idle(); idle();

    // Saturation of the 2-bit counter, then clear coincident with an increment.
    drive(24'd0, 6'd0, 0, 1, 1);
    for (int n = 0; n < 5; n++) drive(24'h000002, 6'h07, 1, 0, 1);
    idle(); idle();
    chk("sat_mc2", 32'(mc2), 32'd3);
    chk("sat_mc8", 32'(mc8), 32'd5);
    drive(24'h000002, 6'h07, 1, 0, 1); idle();
    drive(24'd0, 6'd0, 0, 1, 1);
    chk("clr_prio", {8'(mc8), 6'd0, mc2}, 16'd0);

    // Header in flight discarded by tinit_start low; a header offered while low is ignored.
    drive(24'h000000, 6'h07, 1, 0, 1);
    drive(24'h000000, 6'h07, 1, 0, 0);
    idle();
    chk("tinit_flush", 32'(ov8), 32'd0);
    idle(); idle();
    chk("tinit_nocnt", 32'(sc8), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rh = 24'($urandom);
      re = mparity(rh);
      eh = rh;
      kind = int'($urandom_range(0, 3));
      if (kind == 1) eh = rh ^ (24'd1 << $urandom_range(0, 23));
      if (kind == 2) re = re ^ (6'd1 << $urandom_range(0, 5));
      if (kind == 3) begin
        a = int'($urandom_range(0, 29));
        b = (a + int'($urandom_range(1, 29))) % 30;
        if (a < 24) eh = eh ^ (24'd1 << a); else re = re ^ (6'd1 << (a - 24));
        if (b < 24) eh = eh ^ (24'd1 << b); else re = re ^ (6'd1 << (b - 24));
      end
      if (i == 200) rst_n = 0;
      drive(eh, re, ($urandom_range(0, 4) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 29) != 0));
      if (i == 200) rst_n = 1;
    end
    idle(); idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
